// File: rtl/cc_life_controller_pkg.sv
// Game-wide constants shared by the life controller, playfield and display blocks.
// Holds the life-controller state encoding and the default lives/death-delay values.
package cc_life_controller_pkg;

    localparam int LIVES_WIDTH_DEFAULT = 2;
    localparam int LIVES_INIT_DEFAULT  = 3;
    localparam int DEATH_TICKS_DEFAULT = 60;

    localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
    localparam logic [2:0] ST_RESPAWN_ENC  = 3'd1;
    localparam logic [2:0] ST_PLAYING_ENC  = 3'd2;
    localparam logic [2:0] ST_HIT_ENC      = 3'd3;
    localparam logic [2:0] ST_GAMEOVER_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_RESPAWN  = ST_RESPAWN_ENC,
        ST_PLAYING  = ST_PLAYING_ENC,
        ST_HIT      = ST_HIT_ENC,
        ST_GAMEOVER = ST_GAMEOVER_ENC
    } state_t;

endpackage

// File: rtl/cc_life_controller_tick_timer.sv
// Terminal counter of enabled ticks; o_done strobes on the enabled tick that reaches TERMINAL.
// Holds at TERMINAL until cleared, so it can be reused for level-transition delays.
module cc_tick_timer #(
    parameter int TERMINAL = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_done
);
    localparam int         W      = $clog2(TERMINAL + 1);
    localparam logic [W-1:0] C_TERM = W'(TERMINAL);
    localparam logic [W-1:0] C_LAST = W'(TERMINAL - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != C_TERM)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = i_enable && !i_clear && (r_count == C_LAST);

endmodule

// File: rtl/cc_life_controller.sv
// Frog life budget sequencer: lives register, hit/death freeze, respawn and game-over.
// All outputs are decodes of the state and lives flops; inputs only act through the next edge.
module cc_life_controller
    import cc_life_controller_pkg::*;
#(
    parameter int LIVES_WIDTH = LIVES_WIDTH_DEFAULT,
    parameter int LIVES_INIT  = LIVES_INIT_DEFAULT,
    parameter int DEATH_TICKS = DEATH_TICKS_DEFAULT
) (
    input  logic                   CC_LIFE_CONTROLLER_CLOCK_50,
    input  logic                   CC_LIFE_CONTROLLER_RESET_InLow,
    input  logic                   CC_LIFE_CONTROLLER_tick_In,
    input  logic                   CC_LIFE_CONTROLLER_start_In,
    input  logic                   CC_LIFE_CONTROLLER_collision_In,
    input  logic                   CC_LIFE_CONTROLLER_bonus_In,
    output logic [LIVES_WIDTH-1:0] CC_LIFE_CONTROLLER_lives_OutBUS,
    output logic                   CC_LIFE_CONTROLLER_freeze_Out,
    output logic                   CC_LIFE_CONTROLLER_respawn_Out,
    output logic                   CC_LIFE_CONTROLLER_gameover_Out,
    output logic                   CC_LIFE_CONTROLLER_alive_OutLow
);
    localparam logic [LIVES_WIDTH-1:0] C_LIVES_INIT = LIVES_WIDTH'(LIVES_INIT);
    localparam logic [LIVES_WIDTH-1:0] C_LIVES_MAX  = '1;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [LIVES_WIDTH-1:0] r_lives;
    logic [LIVES_WIDTH-1:0] w_lives_next;
    logic                   w_timer_clear;
    logic                   w_timer_enable;
    logic                   w_timer_done;

    // Clearing on the hit itself means a tick coincident with the collision is not counted.
    assign w_timer_clear  = (r_state == ST_PLAYING) && CC_LIFE_CONTROLLER_collision_In;
    assign w_timer_enable = (r_state == ST_HIT) && CC_LIFE_CONTROLLER_tick_In;

    cc_tick_timer #(
        .TERMINAL (DEATH_TICKS)
    ) u_death_timer (
        .clk      (CC_LIFE_CONTROLLER_CLOCK_50),
        .rst_n    (CC_LIFE_CONTROLLER_RESET_InLow),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_enable),
        .o_done   (w_timer_done)
    );

    always_ff @(posedge CC_LIFE_CONTROLLER_CLOCK_50 or negedge CC_LIFE_CONTROLLER_RESET_InLow) begin
        if (!CC_LIFE_CONTROLLER_RESET_InLow) begin
            r_state <= ST_IDLE;
            r_lives <= '0;
        end else begin
            r_state <= w_state_next;
            r_lives <= w_lives_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_lives_next = r_lives;
        case (r_state)
            ST_IDLE, ST_GAMEOVER: begin
                if (CC_LIFE_CONTROLLER_start_In) begin
                    w_lives_next = C_LIVES_INIT;
                    w_state_next = ST_RESPAWN;
                end
            end
            ST_RESPAWN: begin
                w_state_next = ST_PLAYING;
            end
            ST_PLAYING: begin
                if (CC_LIFE_CONTROLLER_collision_In) begin
                    if (r_lives != '0) begin
                        w_lives_next = r_lives - 1'b1;
                    end
                    w_state_next = ST_HIT;
                end else if (CC_LIFE_CONTROLLER_bonus_In && (r_lives != C_LIVES_MAX)) begin
                    w_lives_next = r_lives + 1'b1;
                end
            end
            ST_HIT: begin
                if (w_timer_done) begin
                    w_state_next = (r_lives == '0) ? ST_GAMEOVER : ST_RESPAWN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign CC_LIFE_CONTROLLER_lives_OutBUS  = r_lives;
    assign CC_LIFE_CONTROLLER_freeze_Out    = (r_state != ST_PLAYING);
    assign CC_LIFE_CONTROLLER_respawn_Out   = (r_state == ST_RESPAWN);
    assign CC_LIFE_CONTROLLER_gameover_Out  = (r_state == ST_GAMEOVER);
    assign CC_LIFE_CONTROLLER_alive_OutLow  = (r_lives != '0);

endmodule

// File: tb/tb_cc_life_controller.sv
// Scoreboard bench for cc_life_controller: directed scenarios followed by random pulses,
// expected outputs come from a lives/phase model and are checked by an independent monitor.
module tb_cc_life_controller;

    localparam int LW    = 2;
    localparam int INIT  = 3;
    localparam int DT    = 4;
    localparam int MAXL  = (1 << LW) - 1;

    logic          clk;
    logic          rst_n;
    logic          tick;
    logic          start;
    logic          coll;
    logic          bonus;
    logic [LW-1:0] lives;
    logic          freeze;
    logic          respawn;
    logic          gameover;
    logic          alive;

    cc_life_controller #(
        .LIVES_WIDTH (LW),
        .LIVES_INIT  (INIT),
        .DEATH_TICKS (DT)
    ) dut (
        .CC_LIFE_CONTROLLER_CLOCK_50     (clk),
        .CC_LIFE_CONTROLLER_RESET_InLow  (rst_n),
        .CC_LIFE_CONTROLLER_tick_In      (tick),
        .CC_LIFE_CONTROLLER_start_In     (start),
        .CC_LIFE_CONTROLLER_collision_In (coll),
        .CC_LIFE_CONTROLLER_bonus_In     (bonus),
        .CC_LIFE_CONTROLLER_lives_OutBUS (lives),
        .CC_LIFE_CONTROLLER_freeze_Out   (freeze),
        .CC_LIFE_CONTROLLER_respawn_Out  (respawn),
        .CC_LIFE_CONTROLLER_gameover_Out (gameover),
        .CC_LIFE_CONTROLLER_alive_OutLow (alive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int lives;
        bit freeze;
        bit resp;
        bit over;
        bit alive;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: the game is in exactly one phase; "idle" is none of the flags set.
    int m_lives;
    bit m_play, m_die, m_resp, m_over;
    int m_left;

    task automatic model_reset();
        m_lives = 0; m_play = 0; m_die = 0; m_resp = 0; m_over = 0; m_left = 0;
    endtask

    task automatic model_apply(input bit s, input bit c, input bit b, input bit t);
        if (m_resp) begin
            m_resp = 0;
            m_play = 1;
        end else if (m_play) begin
            if (c) begin
                if (m_lives > 0) m_lives = m_lives - 1;
                m_play = 0;
                m_die  = 1;
                m_left = DT;
            end else if (b && m_lives < MAXL) begin
                m_lives = m_lives + 1;
            end
        end else if (m_die) begin
            if (t) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_die = 0;
                    if (m_lives == 0) m_over = 1;
                    else              m_resp = 1;
                end
            end
        end else if (s) begin
            m_lives = INIT;
            m_over  = 0;
            m_resp  = 1;
        end
    endtask

    task automatic push(input int due);
        exp_t e;
        e.due    = due;
        e.lives  = m_lives;
        e.freeze = !m_play;
        e.resp   = m_resp;
        e.over   = m_over;
        e.alive  = (m_lives != 0);
        q.push_back(e);
    endtask

    task automatic step(input bit s, input bit c, input bit b);
        @(posedge clk); #1;
        tick  = (cyc % 3 == 0);
        start = s;
        coll  = c;
        bonus = b;
        model_apply(s, c, b, tick);
        push(cyc + 1);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk); #1;
        rst_n = 1'b0;
        tick = 0; start = 0; coll = 0; bonus = 0;
        model_reset();
        q.delete();
        push(cyc);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            push(cyc);
        end
        rst_n = 1'b1;
    endtask

    // Monitor: compares each cycle's DUT outputs with the entry that falls due in that cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #2;
            if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.due != cyc) begin
                    errors++;
                    $display("FAIL sched cyc=%0d: entry due %0d required %0d", cyc, e.due, cyc);
                end
                checks++;
                if (int'(lives) != e.lives) begin
                    errors++;
                    $display("FAIL lives cyc=%0d: got %0d required %0d", cyc, lives, e.lives);
                end
                checks++;
                if (freeze !== e.freeze) begin
                    errors++;
                    $display("FAIL freeze cyc=%0d: got %0b required %0b", cyc, freeze, e.freeze);
                end
                checks++;
                if (respawn !== e.resp) begin
                    errors++;
                    $display("FAIL respawn cyc=%0d: got %0b required %0b", cyc, respawn, e.resp);
                end
                checks++;
                if (gameover !== e.over) begin
                    errors++;
                    $display("FAIL gameover cyc=%0d: got %0b required %0b", cyc, gameover, e.over);
                end
                checks++;
                if (alive !== e.alive) begin
                    errors++;
                    $display("FAIL alive cyc=%0d: got %0b required %0b", cyc, alive, e.alive);
                end
                if (e.resp || e.over)
                    $display("event cyc=%0d respawn=%0b gameover=%0b lives=%0d", cyc, respawn, gameover, lives);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        tick = 0; start = 0; coll = 0; bonus = 0;
        do_reset(3);

        // Pulses in IDLE are ignored, then start the game.
        step(0, 1, 0); step(0, 0, 1); step(0, 1, 1);
        step(1, 0, 0);
        wait_cycles(3);

        // One hit, with stray pulses during the death freeze, then respawn.
        step(0, 1, 0);
        step(0, 1, 1); step(1, 0, 0); step(0, 0, 1);
        wait_cycles(16);

        // Two more hits down to zero lives and game over; pulses in GAMEOVER except start ignored.
        step(0, 1, 0); wait_cycles(16);
        step(0, 1, 0); wait_cycles(16);
        step(0, 1, 1); step(0, 0, 1);
        step(1, 0, 0); wait_cycles(3);

        // Collision beats bonus; bonus saturates at the top.
        step(0, 1, 0); wait_cycles(16);
        step(0, 1, 1); wait_cycles(16);
        step(0, 0, 1); step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
        wait_cycles(2);

        // Reset in the middle of a death freeze, then a normal restart.
        step(0, 1, 0); wait_cycles(4);
        do_reset(2);
        step(1, 0, 0); wait_cycles(4);

        // Random pulses.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 9) == 0);
        end
        wait_cycles(3);

        @(posedge clk); #3;
        checks++;
        if (q.size() > 1) begin
            errors++;
            $display("FAIL drain: %0d entries left required at most 1", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cc_life_controller.md
# cc_life_controller

Sequences the frog's life budget in the Frogger core. It holds the lives register, accepts collision and bonus events from the playfield logic, and freezes the game during a death animation. It then either respawns the frog or declares game over, and re-arms on a start request. Its outputs drive the lives display, the playfield freeze/respawn controls and the game-over screen select.

## Interface
Parameters:
- LIVES_WIDTH, 2, width of the lives register.
- LIVES_INIT, 3, lives loaded on start. Must satisfy 1 ≤ LIVES_INIT ≤ 2^LIVES_WIDTH−1.
- DEATH_TICKS, 60, frame ticks the game stays frozen after a hit. Must be ≥ 1.

Ports:
- CC_LIFE_CONTROLLER_CLOCK_50, in, 1, system clock (50 MHz).
- CC_LIFE_CONTROLLER_RESET_InLow, in, 1, reset; asynchronous, active-low.
- CC_LIFE_CONTROLLER_tick_In, in, 1, one-cycle frame-tick strobe.
- CC_LIFE_CONTROLLER_start_In, in, 1, one-cycle start/restart request.
- CC_LIFE_CONTROLLER_collision_In, in, 1, one-cycle frog-hit pulse.
- CC_LIFE_CONTROLLER_bonus_In, in, 1, one-cycle extra-life pulse.
- CC_LIFE_CONTROLLER_lives_OutBUS, out, LIVES_WIDTH, current lives.
- CC_LIFE_CONTROLLER_freeze_Out, out, 1, holds playfield motion.
- CC_LIFE_CONTROLLER_respawn_Out, out, 1, one-cycle pulse that resets the frog to the start row.
- CC_LIFE_CONTROLLER_gameover_Out, out, 1, game-over screen select.
- CC_LIFE_CONTROLLER_alive_OutLow, out, 1, 0 when lives == 0, else 1.

## Operation
- FSM states: IDLE, RESPAWN, PLAYING, HIT, GAMEOVER.
- IDLE:
  - freeze=1.
  - start → load lives=LIVES_INIT → RESPAWN.
  - collision, bonus and tick are ignored.
- RESPAWN:
  - Lasts exactly one cycle; respawn=1, freeze=1.
  - Then → PLAYING unconditionally.
- PLAYING:
  - freeze=0.
  - collision → lives decremented, saturating at 0 → HIT; timer cleared.
  - bonus without collision → lives incremented, saturating at 2^LIVES_WIDTH−1; stay in PLAYING.
  - collision and bonus in the same cycle: collision wins, bonus dropped.
  - start is ignored.
- HIT:
  - freeze=1.
  - Timer increments on each tick.
  - On the tick that makes the count equal DEATH_TICKS: → GAMEOVER if lives==0, else → RESPAWN.
  - collision, bonus and start are ignored.
- GAMEOVER:
  - gameover=1, freeze=1.
  - start → reload lives=LIVES_INIT → RESPAWN.
- alive_OutLow is a pure decode of the lives register.

## Timing
- Reset values:
  - State IDLE, timer 0.
  - lives=0, alive_OutLow=0.
  - freeze=1, respawn=0, gameover=0.
- Reset is asynchronous assert. Deassertion is synchronised externally.
- Reset asserted mid-game (any state, including mid-HIT) returns all registers to reset values immediately.
- Inputs are sampled on the rising clock edge. The effect is visible in outputs one cycle later.
- There is no combinational path from any input to any output. Outputs are registers or decodes of the state and lives flops only.
- Collision in cycle N:
  - lives is decremented and freeze=1 from cycle N+1.
- Respawn sequence:
  - The HIT→RESPAWN transition occurs on the DEATH_TICKS-th tick after entry.
  - respawn is high for exactly one cycle.
  - freeze falls the cycle after respawn.
- A tick coincident with the collision cycle does not count toward the timer.
- Timer width is clog2(DEATH_TICKS+1). The timer is only advanced in HIT and cleared on HIT entry.
- Lives arithmetic is unsigned LIVES_WIDTH bits. No wrap in either direction.

## Structure
- Shared package (game-wide constants file) holds:
  - The state encoding localparams (3-bit binary).
  - Default LIVES_INIT and DEATH_TICKS, so the playfield and display blocks agree.
- One natural sub-module: cc_tick_timer. It is a DEATH_TICKS-terminal counter with clear, enable (tick) and done outputs, and is reused later for level-transition delays.
- The lives register and FSM stay in the top module.

## Test plan
Use DEATH_TICKS=4 and a tick every 3 cycles.
1. Reset release, then start pulse → respawn high for one cycle, lives=3, alive_OutLow=1, freeze=0 on the next cycle.
2. Collision in PLAYING → lives 3→2 next cycle, freeze=1 for exactly 4 ticks, one respawn pulse, then freeze=0.
3. Three collisions, each after respawn → lives=0, alive_OutLow=0, gameover=1 after the 4th tick, no respawn pulse; a later start gives lives=3 and a respawn pulse.
4. Collision and bonus in the same cycle with lives=2 → lives=1; bonus at lives=3 → stays at 3; bonus at lives=1 → 2.
5. Collisions, bonuses and starts during HIT and IDLE → no change to lives or state.
6. Reset asserted mid-HIT, between ticks → immediate lives=0, freeze=1, gameover=0, state IDLE; a start then yields a normal respawn.
